// File: rtl/fft_out_reorder_if.sv
// Sample bus between the FFT normalizer and the output reorder buffer.
// The master side drives bit-reversed input samples; the slave side
// returns natural-order samples with frame status.
interface fft_out_reorder_if #(
    parameter int nb = 12
);
    logic                ed;
    logic                start;
    logic signed [nb+1:0] dr;
    logic signed [nb+1:0] di;
    logic                ovfi;
    logic signed [nb+1:0] dor;
    logic signed [nb+1:0] doi;
    logic [7:0]          addr;
    logic                rdy;
    logic                ovf;
    logic                ferr;

    modport master (
        output ed, start, dr, di, ovfi,
        input  dor, doi, addr, rdy, ovf, ferr
    );

    modport slave (
        input  ed, start, dr, di, ovfi,
        output dor, doi, addr, rdy, ovf, ferr
    );
endinterface

// File: rtl/fft_out_reorder.sv
// FFT output reorder buffer: accepts 256-point frames in bit-reversed
// order, stores them in one of two ping-pong banks and streams the
// previously completed frame out in natural order.
module fft_out_reorder #(
    parameter int nb = 12
) (
    input  logic              CLK,
    input  logic              rst,
    fft_out_reorder_if.slave  bus
);
    localparam int W = nb + 2;

    typedef enum logic {IDLE, FILL} wr_state_t;

    // write side
    wr_state_t  state_reg, state_next;
    logic [7:0] wc_reg, wc_next;
    logic       wbank_reg, wbank_next;
    logic       acc_reg, acc_next;
    logic       ferr_next;
    logic       we;
    logic       frame_done;
    logic [7:0] waddr;
    logic [7:0] wc_rev;

    // read side
    logic       rd_active_reg;
    logic       rbank_reg;
    logic [7:0] rc_reg;
    logic       rovf_reg;
    logic       rd_vld_reg;
    logic [7:0] rd_idx_reg;

    // output stage
    logic signed [W-1:0] dor_reg, doi_reg;
    logic [7:0]          addr_reg;
    logic                rdy_reg, ovf_reg, ferr_reg;

    // both banks live in one array; the bank bit is the address MSB
    logic [2*W-1:0] mem [0:511];
    logic [2*W-1:0] rdata_reg;

    // bit-reversed write counter selects the natural-order slot
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rev
            assign wc_rev[gi] = wc_reg[7-gi];
        end
    endgenerate

    // write FSM: next state, counter, bank, overflow accumulation, abort detect
    always_comb begin
        state_next = state_reg;
        wc_next    = wc_reg;
        wbank_next = wbank_reg;
        acc_next   = acc_reg;
        ferr_next  = 1'b0;
        we         = 1'b0;
        waddr      = wc_rev;
        frame_done = 1'b0;
        if (bus.ed) begin
            if (bus.start) begin
                // a START inside a partly filled frame discards it in place
                we         = 1'b1;
                waddr      = 8'd0;
                wc_next    = 8'd1;
                acc_next   = bus.ovfi;
                state_next = FILL;
                ferr_next  = (state_reg == FILL) && (wc_reg != 8'd0);
            end else if (state_reg == FILL) begin
                we       = 1'b1;
                acc_next = acc_reg | bus.ovfi;
                if (wc_reg == 8'd255) begin
                    frame_done = 1'b1;
                    wc_next    = 8'd0;
                    wbank_next = ~wbank_reg;
                    state_next = IDLE;
                end else begin
                    wc_next = wc_reg + 8'd1;
                end
            end
        end
    end

    // write FSM state register
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            wc_reg    <= 8'd0;
            wbank_reg <= 1'b0;
            acc_reg   <= 1'b0;
            ferr_reg  <= 1'b0;
        end else if (bus.ed) begin
            state_reg <= state_next;
            wc_reg    <= wc_next;
            wbank_reg <= wbank_next;
            acc_reg   <= acc_next;
            ferr_reg  <= ferr_next;
        end
    end

    // read control: a completed frame starts (or seamlessly continues) the readout
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            rd_active_reg <= 1'b0;
            rbank_reg     <= 1'b0;
            rc_reg        <= 8'd0;
            rovf_reg      <= 1'b0;
            rd_vld_reg    <= 1'b0;
            rd_idx_reg    <= 8'd0;
        end else if (bus.ed) begin
            rd_vld_reg <= rd_active_reg;
            rd_idx_reg <= rc_reg;
            if (frame_done) begin
                // frames are at least 256 ED cycles apart, so the reader is
                // either idle or on its last address here
                rd_active_reg <= 1'b1;
                rbank_reg     <= wbank_reg;
                rc_reg        <= 8'd0;
                rovf_reg      <= acc_next;
            end else if (rd_active_reg) begin
                rc_reg <= rc_reg + 8'd1;
                if (rc_reg == 8'd255) begin
                    rd_active_reg <= 1'b0;
                end
            end
        end
    end

    // ping-pong sample storage with registered read
    always_ff @(posedge CLK) begin
        if (bus.ed) begin
            if (we) begin
                mem[{wbank_reg, waddr}] <= {bus.dr, bus.di};
            end
            if (rd_active_reg) begin
                rdata_reg <= mem[{rbank_reg, rc_reg}];
            end
        end
    end

    // output register: holds last sample when no readout is in progress
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            dor_reg  <= '0;
            doi_reg  <= '0;
            addr_reg <= 8'd0;
            rdy_reg  <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (bus.ed) begin
            if (rd_vld_reg) begin
                dor_reg  <= rdata_reg[2*W-1:W];
                doi_reg  <= rdata_reg[W-1:0];
                addr_reg <= rd_idx_reg;
                rdy_reg  <= (rd_idx_reg == 8'd0);
                if (rd_idx_reg == 8'd0) begin
                    ovf_reg <= rovf_reg;
                end
            end else begin
                rdy_reg <= 1'b0;
            end
        end
    end

    assign bus.dor  = dor_reg;
    assign bus.doi  = doi_reg;
    assign bus.addr = addr_reg;
    assign bus.rdy  = rdy_reg;
    assign bus.ovf  = ovf_reg;
    assign bus.ferr = ferr_reg;
endmodule

// File: tb/tb_fft_out_reorder.sv
// Bench for the FFT output reorder buffer: a frame-level model predicts
// every output, checked each clock, plus literal spot checks.
module tb_fft_out_reorder;
    localparam int NB = 12;
    localparam int W  = NB + 2;

    logic CLK = 1'b0;
    logic rst = 1'b1;

    fft_out_reorder_if #(.nb(NB)) bus();

    fft_out_reorder #(.nb(NB)) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = v[7-b];
        return r;
    endfunction

    // ---------------- frame-level model ----------------
    typedef struct {
        int         edge_no;
        logic [W-1:0] r;
        logic [W-1:0] i;
        logic [7:0] a;
        bit         ovf;
    } ent_t;

    ent_t         sched[$];
    logic [2*W-1:0] frame_mem [256];
    bit           in_frame;
    int           cnt;
    bit           facc;
    int           ecount;
    bit           last_ed;
    int           frames_out;
    logic [W-1:0] e_dor, e_doi;
    logic [7:0]   e_addr;
    bit           e_rdy, e_ovf, e_ferr;
    int           rdy_cnt, ferr_cnt;

    task model_reset();
        sched.delete();
        in_frame = 0;
        cnt      = 0;
        facc     = 0;
        last_ed  = 0;
        e_dor    = '0;
        e_doi    = '0;
        e_addr   = 8'd0;
        e_rdy    = 0;
        e_ovf    = 0;
        e_ferr   = 0;
    endtask

    // predict outputs after the coming clock edge from the inputs now on the bus
    task model_step();
        ent_t ent;
        last_ed = bus.ed;
        if (!bus.ed) return;
        ecount++;
        e_ferr = 0;
        if (bus.start) begin
            if (in_frame && cnt != 0) e_ferr = 1;
            in_frame = 1;
            cnt      = 0;
            facc     = bus.ovfi;
        end else if (in_frame) begin
            facc = facc | bus.ovfi;
        end
        if (in_frame) begin
            frame_mem[rev8(8'(cnt))] = {bus.dr, bus.di};
            cnt++;
            if (cnt == 256) begin
                for (int n = 0; n < 256; n++) begin
                    ent.edge_no = ecount + 2 + n;
                    ent.r       = frame_mem[n][2*W-1:W];
                    ent.i       = frame_mem[n][W-1:0];
                    ent.a       = 8'(n);
                    ent.ovf     = facc;
                    sched.push_back(ent);
                end
                in_frame = 0;
                cnt      = 0;
            end
        end
        e_rdy = 0;
        if (sched.size() > 0 && sched[0].edge_no == ecount) begin
            ent    = sched.pop_front();
            e_dor  = ent.r;
            e_doi  = ent.i;
            e_addr = ent.a;
            if (ent.a == 8'd0) begin
                e_rdy = 1;
                e_ovf = ent.ovf;
                frames_out++;
                $display("frame %0d ready at ED edge %0d, ovf=%0d", frames_out, ecount, ent.ovf);
            end
        end
    endtask

    // compare process: outputs checked on every falling edge
    initial begin
        ecount     = 0;
        frames_out = 0;
        rdy_cnt    = 0;
        ferr_cnt   = 0;
        model_reset();
        forever begin
            @(negedge CLK);
            if (rst) model_reset();
            chk("dor",  {18'd0, bus.dor},  {18'd0, e_dor});
            chk("doi",  {18'd0, bus.doi},  {18'd0, e_doi});
            chk("addr", {24'd0, bus.addr}, {24'd0, e_addr});
            chk("rdy",  {31'd0, bus.rdy},  {31'd0, e_rdy});
            chk("ovf",  {31'd0, bus.ovf},  {31'd0, e_ovf});
            chk("ferr", {31'd0, bus.ferr}, {31'd0, e_ferr});
            if (last_ed && bus.rdy)  rdy_cnt++;
            if (last_ed && bus.ferr) ferr_cnt++;
            if (!rst) model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic ed, input logic start, input int dr, input int di, input logic ovfi);
        @(posedge CLK);
        #2;
        bus.ed    = ed;
        bus.start = start;
        bus.dr    = W'(dr);
        bus.di    = W'(di);
        bus.ovfi  = ovfi;
    endtask

    task automatic send_frame(input int base, input int ovf_idx);
        for (int k = 0; k < 256; k++) begin
            drive(1'b1, k == 0, base + k, -(base + k), k == ovf_idx);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int k, cyc, rdy0, ferr0;
        bit hit;
        bus.ed = 0; bus.start = 0; bus.dr = '0; bus.di = '0; bus.ovfi = 0;
        repeat (3) @(posedge CLK);
        #2 rst = 1'b0;
        @(negedge CLK);
        chk("reset_dor",  {18'd0, bus.dor}, 32'd0);
        chk("reset_rdy",  {31'd0, bus.rdy}, 32'd0);
        chk("reset_addr", {24'd0, bus.addr}, 32'd0);

        // ramp: DR=k at bit-reversed index k
        $display("test ramp");
        send_frame(0, -1);
        @(posedge CLK);
        #2;
        bus.ed = 1'b1; bus.start = 1'b0; bus.dr = '0; bus.di = '0;
        @(negedge CLK);
        chk("ramp_rdy_e0", {31'd0, bus.rdy}, 32'd0);
        @(negedge CLK);
        chk("ramp_rdy_e1", {31'd0, bus.rdy}, 32'd0);
        @(negedge CLK);
        chk("ramp_rdy_e2",  {31'd0, bus.rdy},  32'd1);
        chk("ramp_addr0",   {24'd0, bus.addr}, 32'd0);
        chk("ramp_dor0",    {18'd0, bus.dor},  32'd0);
        chk("ramp_ovf",     {31'd0, bus.ovf},  32'd0);
        @(negedge CLK);
        chk("ramp_addr1",   {24'd0, bus.addr}, 32'd1);
        chk("ramp_dor1",    {18'd0, bus.dor},  32'd128);
        chk("ramp_doi1",    {18'd0, bus.doi},  32'h3F80);
        @(negedge CLK);
        chk("ramp_dor2",    {18'd0, bus.dor},  32'd64);
        idle(300);

        // overflow on sample 100, then a clean frame back to back
        $display("test overflow");
        send_frame(2000, 100);
        for (int j = 0; j < 256; j++) begin
            drive(1'b1, j == 0, 3000 + j, -(3000 + j), 1'b0);
            if (j == 10) chk("ovf_set", {31'd0, bus.ovf}, 32'd1);
        end
        idle(270);
        chk("ovf_clear", {31'd0, bus.ovf}, 32'd0);

        // stall: random ED with junk on ED=0 cycles
        $display("test stall");
        k = 0;
        cyc = 0;
        while (k < 256 && cyc < 5000) begin
            if ($urandom_range(0, 1) == 1) begin
                drive(1'b1, k == 0, k, -k, 1'b0);
                k++;
            end else begin
                drive(1'b0, 1'b1, 777, -777, 1'b1);
            end
            cyc++;
        end
        chk("stall_samples", k, 256);
        repeat (800) drive(1'($urandom_range(0, 1)), 1'b0, 555, 555, 1'b1);
        idle(5);

        // abort: START at wc=50, then a complete frame
        $display("test abort");
        rdy0  = rdy_cnt;
        ferr0 = ferr_cnt;
        for (int j = 0; j < 50; j++) drive(1'b1, j == 0, 1000 + j, -(1000 + j), 1'b0);
        send_frame(1500, -1);
        idle(270);
        chk("abort_ferr_count", ferr_cnt - ferr0, 1);
        chk("abort_rdy_count",  rdy_cnt - rdy0,   1);

        // streaming: four frames back to back with random data
        $display("test streaming");
        rdy0 = rdy_cnt;
        for (int f = 0; f < 4; f++) begin
            for (int j = 0; j < 256; j++) begin
                drive(1'b1, j == 0, int'($urandom_range(0, 16383)) - 8192,
                      int'($urandom_range(0, 16383)) - 8192, 1'b0);
            end
        end
        idle(270);
        chk("stream_rdy_count", rdy_cnt - rdy0, 4);

        // reset during readout at ADDR=128
        $display("test reset");
        send_frame(0, -1);
        hit = 0;
        for (int j = 0; j < 400 && !hit; j++) begin
            drive(1'b1, 1'b0, 0, 0, 1'b0);
            if (bus.addr == 8'd128) hit = 1;
        end
        chk("reset_reach_128", {31'd0, hit}, 32'd1);
        rst = 1'b1;
        @(negedge CLK);
        chk("rst_addr", {24'd0, bus.addr}, 32'd0);
        chk("rst_dor",  {18'd0, bus.dor},  32'd0);
        chk("rst_rdy",  {31'd0, bus.rdy},  32'd0);
        repeat (2) @(posedge CLK);
        #2 rst = 1'b0;
        rdy0 = rdy_cnt;
        for (int j = 0; j < 50; j++) drive(1'b1, 1'b0, 9 + j, j, 1'b0);
        idle(20);
        chk("post_reset_no_rdy", rdy_cnt - rdy0, 0);
        send_frame(100, -1);
        idle(270);
        chk("post_reset_rdy", rdy_cnt - rdy0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_out_reorder.md
FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

Interface
REQ-001 Parameter nb, default 12: input sample width is nb+2 bits per component, matching the normalizer output.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 ED  input  1  enable; all state advances only on CLK edges with ED=1, otherwise held.
REQ-005 START  input  1  frame-start flag; marks DR/DI as bit-reversed sample index 0.
REQ-006 DR, DI  input  nb+2 each  signed real/imag samples in bit-reversed order.
REQ-007 OVFI  input  1  per-sample overflow flag aligned with DR/DI.
REQ-008 DOR, DOI  output  nb+2 each  signed samples in natural order, registered.
REQ-009 ADDR  output  8  natural-order index of the current DOR/DOI.
REQ-010 RDY  output  1  one ED-cycle pulse with natural index 0 of each frame.
REQ-011 OVF  output  1  frame overflow flag, valid from RDY until the next RDY.
REQ-012 FERR  output  1  one ED-cycle pulse on an aborted partial frame.

Function
REQ-013 Storage shall be two banks of 256 x 2(nb+2) bits, ping-pong: one bank filled while the other is read.
REQ-014 Write side shall have states IDLE and FILL plus an 8-bit write counter wc.
REQ-015 IDLE: input ignored until ED and START both high.
REQ-016 Each ED cycle in FILL, or with START, shall store {DR,DI} at address bitrev8(wc) of the write bank and increment wc.
REQ-017 START=1 shall force wc=0 for that sample and enter FILL.
REQ-018 Frame OVF accumulator: set to OVFI on START, ORed with OVFI on every other FILL write.
REQ-019 Write of wc=255 shall complete the frame: toggle write bank, hand the filled bank and its OVF to the read side, return to IDLE; a START on the next ED cycle shall be accepted with no gap.
REQ-020 START with wc!=0 in FILL shall discard the partial frame, pulse FERR on the next ED edge, and restart at wc=0 in the same bank; no bank toggle, no output for the discarded frame.
REQ-021 Read side: 8-bit counter rc, synchronous RAM read, one output register stage.
REQ-022 Read side shall start on the ED cycle after frame completion and read addresses 0..255 in natural order, one per ED cycle.
REQ-023 Latency: DOR/DOI = X[0], ADDR=0, RDY=1 shall appear after the 2nd ED-qualified edge following the edge that wrote wc=255.
REQ-024 OVF shall update with RDY and hold until the next frame's RDY.
REQ-025 Back-to-back frames (START every 256 ED cycles) shall stream continuously, with ADDR wrapping 255->0 and RDY for the new frame.
REQ-026 When no frame is pending after address 255, DOR/DOI/ADDR shall hold their last values and RDY shall stay 0.
REQ-027 Data shall pass bit-exact; no rounding, saturation or sign change.
REQ-028 Read and write shall never address the same bank in the same cycle.

Reset
REQ-029 RST=1 shall asynchronously force:
- DOR, DOI, ADDR, RDY, OVF, FERR = 0
- write state IDLE, wc=0, rc=0, read inactive, write bank 0.
REQ-030 Reset mid-frame or mid-readout shall discard all frames in flight.
REQ-031 RAM contents need not be reset.
REQ-032 After reset release, no RDY shall occur before a complete 256-sample frame.

Verification
REQ-033 Ramp test: ED=1, START with DR=k, DI=-k at bit-reversed index k, 256 samples -> RDY 2 cycles after last input; DOR=bitrev8(n) at ADDR=n for n=0..255; OVF=0.
REQ-034 Overflow: OVFI=1 only on sample 100 -> OVF=1 with this frame's RDY, through its 256 outputs; next clean frame -> OVF=0 at its RDY.
REQ-035 Stall: ED toggled pseudo-randomly -> identical output sequence to the ramp test; no state change on ED=0 cycles.
REQ-036 Abort: START at wc=50, then full frame -> one FERR pulse; exactly one RDY; outputs from the second frame only.
REQ-037 Streaming: 4 back-to-back frames -> 1024 contiguous outputs; RDY every 256 ED cycles; ADDR wraps 255->0 with no gap.
REQ-038 Reset: RST during readout at ADDR=128 -> all outputs 0 immediately; no RDY until a new complete frame.
